trace_dispatcher: RTL and testbench

Consumer end of the trace repository's request and mark-done interfaces. It pulls trace entries one at a time with `trace_req`, issues each entry's memory address to a downstream operation port, and tracks issued addresses in a small in-order in-flight queue. When a downstream operation completes, it marks that address done back in the repository with a `mark_done`/`marked_valid` handshake. It sits between the trace repository and the Enokida processing logic.

---
 rtl/trace_dispatcher.sv | 201 ++++++++++++++++++++
 tb/tb_trace_dispatcher.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dispatcher.sv
// Pulls trace entries from the repository, issues each address downstream, and
// marks addresses done in the repository, oldest first, as operations complete.
module trace_dispatcher #(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int INFLIGHT_DEPTH  = 4,
  parameter int RETRY_GAP       = 8,
  parameter int TRACE_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       trace_req,
  input  logic [TRACE_WIDTH-1:0]     trace_in,
  input  logic                       entry_valid,
  input  logic                       processing_complete,
  output logic [DATA_ADDR_WIDTH-1:0] addr_done,
  output logic                       mark_done,
  input  logic                       marked,
  input  logic                       marked_valid,
  output logic                       op_valid,
  output logic [DATA_ADDR_WIDTH-1:0] op_addr,
  input  logic                       op_ready,
  input  logic                       op_done,
  output logic                       idle,
  output logic [15:0]                retired_count,
  output logic                       protocol_error,
  output logic [1:0]                 dbg_req_state,
  output logic                       dbg_mark_state
);

  localparam int PTR_W = $clog2(INFLIGHT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(RETRY_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_WAIT} req_state_t;
  typedef enum logic {M_IDLE, M_MARK} mark_state_t;

  // Handshakes: op_valid/op_addr hold until op_ready is sampled high; mark_done/
  // addr_done hold until marked_valid is sampled high; trace_req/entry_valid
  // capture on the edge where both are high.
  req_state_t                 state_q, state_d;
  mark_state_t                mstate_q, mstate_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [DATA_ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_done_q, addr_done_d;
  logic                       trace_req_q, trace_req_d;
  logic                       op_valid_q, op_valid_d;
  logic                       mark_done_q, mark_done_d;
  logic                       idle_q, idle_d;
  logic                       err_q, err_d;
  logic [15:0]                retired_q, retired_d;
  logic [DATA_ADDR_WIDTH-1:0] mem_q [INFLIGHT_DEPTH];
  logic [DATA_ADDR_WIDTH-1:0] mem_d [INFLIGHT_DEPTH];
  logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d, done_cnt_q, done_cnt_d;
  logic                       push, pop, done_inc, full;
  logic                       unused_trace;

  // Only the low DATA_ADDR_WIDTH bits of a trace entry (mem_addr) are consumed.
  assign unused_trace = ^trace_in;
  assign full         = (count_q == CNT_W'(INFLIGHT_DEPTH));

  always_comb begin
    state_d   = state_q;
    op_addr_d = op_addr_q;
    gap_d     = gap_q;
    push      = 1'b0;
    case (state_q)
      S_IDLE: if (enable && !full) state_d = S_REQ;
      S_REQ: begin
        if (entry_valid) begin
          op_addr_d = trace_in[DATA_ADDR_WIDTH-1:0];
          state_d   = S_ISSUE;
        end else if (processing_complete) begin
          gap_d   = GAP_W'(RETRY_GAP);
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    trace_req_d = (state_d == S_REQ);
    op_valid_d  = (state_d == S_ISSUE);
  end

  always_comb begin
    mstate_d    = mstate_q;
    addr_done_d = addr_done_q;
    err_d       = err_q;
    pop         = 1'b0;
    done_inc    = 1'b0;
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    done_cnt_d  = done_cnt_q;
    retired_d   = retired_q;
    case (mstate_q)
      M_IDLE: begin
        if (done_cnt_q != '0) begin
          mstate_d    = M_MARK;
          addr_done_d = mem_q[head_q];
        end
      end
      M_MARK: begin
        if (marked_valid) begin
          pop      = 1'b1;
          mstate_d = M_IDLE;
          if (!marked) err_d = 1'b1;
        end
      end
      default: mstate_d = M_IDLE;
    endcase
    // A completion with every outstanding entry already done has nothing to retire.
    if (op_done) begin
      if (done_cnt_q == count_q) err_d = 1'b1;
      else done_inc = 1'b1;
    end
    if (push) begin
      mem_d[tail_q] = op_addr_q;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d    = head_q + PTR_W'(1);
      retired_d = retired_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({done_inc, pop})
      2'b10:   done_cnt_d = done_cnt_q + CNT_W'(1);
      2'b01:   done_cnt_d = done_cnt_q - CNT_W'(1);
      default: done_cnt_d = done_cnt_q;
    endcase
    mark_done_d = (mstate_d == M_MARK);
  end

  assign idle_d = ((state_d == S_IDLE) || (state_d == S_WAIT)) &&
                  (count_d == '0) && (mstate_d == M_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mstate_q    <= M_IDLE;
      gap_q       <= '0;
      op_addr_q   <= '0;
      addr_done_q <= '0;
      trace_req_q <= 1'b0;
      op_valid_q  <= 1'b0;
      mark_done_q <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      retired_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      done_cnt_q  <= '0;
      for (int i = 0; i < INFLIGHT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mstate_q    <= mstate_d;
      gap_q       <= gap_d;
      op_addr_q   <= op_addr_d;
      addr_done_q <= addr_done_d;
      trace_req_q <= trace_req_d;
      op_valid_q  <= op_valid_d;
      mark_done_q <= mark_done_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      done_cnt_q  <= done_cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign trace_req      = trace_req_q;
  assign op_valid       = op_valid_q;
  assign op_addr        = op_addr_q;
  assign mark_done      = mark_done_q;
  assign addr_done      = addr_done_q;
  assign idle           = idle_q;
  assign retired_count  = retired_q;
  assign protocol_error = err_q;
  assign dbg_req_state  = state_q;
  assign dbg_mark_state = mstate_q;

endmodule

// File: tb/tb_trace_dispatcher.sv
// Directed bench for trace_dispatcher: a combinational repository model, a mark
// responder, and a negedge monitor that scores op and mark handshakes in order.
module tb_trace_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        trace_req;
  logic [31:0] trace_in;
  logic        entry_valid;
  logic        processing_complete;
  logic [15:0] addr_done;
  logic        mark_done;
  logic        marked;
  logic        marked_valid;
  logic        op_valid;
  logic [15:0] op_addr;
  logic        op_ready;
  logic        op_done;
  logic        idle;
  logic [15:0] retired_count;
  logic        protocol_error;
  logic [1:0]  dbg_req_state;
  logic        dbg_mark_state;

  trace_dispatcher dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .trace_req           (trace_req),
    .trace_in            (trace_in),
    .entry_valid         (entry_valid),
    .processing_complete (processing_complete),
    .addr_done           (addr_done),
    .mark_done           (mark_done),
    .marked              (marked),
    .marked_valid        (marked_valid),
    .op_valid            (op_valid),
    .op_addr             (op_addr),
    .op_ready            (op_ready),
    .op_done             (op_done),
    .idle                (idle),
    .retired_count       (retired_count),
    .protocol_error      (protocol_error),
    .dbg_req_state       (dbg_req_state),
    .dbg_mark_state      (dbg_mark_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          op_seen = 0;
  int          req_rises = 0;
  logic [15:0] exp_op_q[$];
  logic [15:0] exp_mark_q[$];
  logic [15:0] issued_q[$];

  // repository model
  logic [15:0] repo_mem [0:31];
  logic [4:0]  repo_rd = '0;
  logic [4:0]  repo_wr = '0;
  logic        pc_en;
  logic        pc_force;
  logic        mark_auto;
  logic        mark_ok;

  assign entry_valid         = trace_req && (repo_rd != repo_wr);
  assign trace_in            = {16'hBEEF, repo_mem[repo_rd]};
  assign processing_complete = pc_force || (pc_en && (repo_rd == repo_wr));

  always @(posedge clk) begin
    if (rst_n && trace_req && entry_valid) repo_rd <= repo_rd + 5'd1;
  end

  // mark responder: one-cycle marked_valid the cycle after mark_done is seen
  initial begin
    marked_valid = 1'b0;
    marked       = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      marked       = mark_ok;
      marked_valid = mark_auto && mark_done && !marked_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic        prev_md;
    logic        prev_req;
    logic [15:0] prev_ad;
    prev_md  = 1'b0;
    prev_req = 1'b0;
    prev_ad  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (op_valid && op_ready) begin
          op_seen++;
          if (exp_op_q.size() == 0) check("op_extra", 32'(exp_op_q.size()), 1);
          else check("op_addr", 32'(op_addr), 32'(exp_op_q.pop_front()));
        end
        if (mark_done && marked_valid) begin
          if (exp_mark_q.size() == 0) check("mark_extra", 32'(exp_mark_q.size()), 1);
          else check("addr_done", 32'(addr_done), 32'(exp_mark_q.pop_front()));
        end
        if (mark_done && prev_md) check("addr_done_stable", 32'(addr_done), 32'(prev_ad));
        if (trace_req && !prev_req) req_rises++;
      end
      prev_md  = mark_done;
      prev_ad  = addr_done;
      prev_req = trace_req;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [15:0] a);
    repo_mem[repo_wr] = a;
    repo_wr = repo_wr + 5'd1;
    exp_op_q.push_back(a);
    issued_q.push_back(a);
  endtask

  task automatic enable_pulse();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic pulse_op_done(input int n);
    for (int i = 0; i < n; i++) exp_mark_q.push_back(issued_q.pop_front());
    op_done = 1'b1;
    repeat (n) tick();
    op_done = 1'b0;
  endtask

  task automatic wait_op(input int n, input int budget);
    int target;
    int cnt;
    target = op_seen + n;
    cnt = 0;
    while (op_seen < target && cnt < budget) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("op_handshakes", 32'(op_seen), 32'(target));
    tick();
  endtask

  task automatic wait_marks(input logic need_idle, input int budget);
    int cnt;
    cnt = 0;
    while (!(exp_mark_q.size() == 0 && (idle || !need_idle)) && cnt < budget) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("marks_drained", 32'(exp_mark_q.size() == 0 && (idle || !need_idle)), 1);
    tick();
  endtask

  initial begin
    int base_ops;
    int base_req;
    int n;
    int low;
    int idl;
    rst_n     = 1'b0;
    enable    = 1'b0;
    op_ready  = 1'b0;
    op_done   = 1'b0;
    pc_en     = 1'b0;
    pc_force  = 1'b0;
    mark_auto = 1'b1;
    mark_ok   = 1'b1;
    tick();
    tick();
    check("rst_trace_req", 32'(trace_req), 0);
    check("rst_mark_done", 32'(mark_done), 0);
    check("rst_addr_done", 32'(addr_done), 0);
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_op_addr", 32'(op_addr), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_retired", 32'(retired_count), 0);
    check("rst_error", 32'(protocol_error), 0);
    rst_n = 1'b1;
    tick();

    // single entry
    push_entry(16'h1234);
    op_ready = 1'b1;
    enable_pulse();
    wait_op(1, 30);
    repeat (3) tick();
    pulse_op_done(1);
    wait_marks(1'b1, 40);
    repeat (2) tick();
    check("single_op_addr", 32'(op_addr), 32'h1234);
    check("single_addr_done", 32'(addr_done), 32'h1234);
    check("single_retired", 32'(retired_count), 1);
    check("single_idle", 32'(idle), 1);
    check("single_error", 32'(protocol_error), 0);

    // back-pressure: stall on op_ready, then a full queue with no completions
    base_ops = op_seen;
    base_req = req_rises;
    op_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_entry(16'h00A0 + 16'(i));
    enable = 1'b1;
    repeat (6) tick();
    check("stall_op_valid", 32'(op_valid), 1);
    check("stall_op_addr", 32'(op_addr), 32'h00A0);
    op_ready = 1'b1;
    repeat (40) tick();
    check("full_pushes", 32'(op_seen - base_ops), 4);
    check("full_req_count", 32'(req_rises - base_req), 4);
    check("full_trace_req", 32'(trace_req), 0);
    pulse_op_done(1);
    repeat (20) tick();
    check("refill_pushes", 32'(op_seen - base_ops), 5);
    check("refill_req_count", 32'(req_rises - base_req), 5);
    for (int i = 0; i < 4; i++) pulse_op_done(1);
    repeat (20) tick();
    pulse_op_done(1);
    wait_marks(1'b0, 80);
    repeat (2) tick();
    check("bp_retired", 32'(retired_count), 7);
    check("bp_pushes", 32'(op_seen - base_ops), 6);
    check("bp_error", 32'(protocol_error), 0);

    // drain and retry gap (DUT is parked in a request with enable high)
    pc_en = 1'b1;
    @(negedge clk);
    n = 0;
    while (trace_req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    low = 0;
    idl = 0;
    while (trace_req === 1'b0 && low < 40) begin
      low++;
      if (idle) idl++;
      @(negedge clk);
    end
    check("retry_low_cycles", 32'(low), 9);
    check("retry_idle_cycles", 32'(idl), 9);
    tick();
    enable = 1'b0;
    repeat (15) tick();
    pc_en = 1'b0;
    tick();
    check("drained_idle", 32'(idle), 1);
    check("drained_trace_req", 32'(trace_req), 0);

    // ordering, entry_valid beating processing_complete, op_done with marked_valid
    pc_force = 1'b1;
    push_entry(16'h0010);
    push_entry(16'h0020);
    push_entry(16'h0030);
    enable = 1'b1;
    wait_op(3, 40);
    enable   = 1'b0;
    pc_force = 1'b0;
    pulse_op_done(3);
    wait_marks(1'b1, 60);
    repeat (2) tick();
    check("order_retired", 32'(retired_count), 10);
    check("order_error", 32'(protocol_error), 0);
    check("order_idle", 32'(idle), 1);

    // op_done with an empty queue
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    tick();
    check("err_empty_op_done", 32'(protocol_error), 1);
    repeat (5) tick();
    check("err_sticky", 32'(protocol_error), 1);

    // reset in the middle of a mark
    push_entry(16'h0077);
    enable_pulse();
    wait_op(1, 30);
    mark_auto = 1'b0;
    pulse_op_done(1);
    repeat (4) tick();
    check("midmark_mark_done", 32'(mark_done), 1);
    check("midmark_addr_done", 32'(addr_done), 32'h0077);
    rst_n = 1'b0;
    tick();
    tick();
    exp_mark_q.delete();
    check("rst2_mark_done", 32'(mark_done), 0);
    check("rst2_addr_done", 32'(addr_done), 0);
    check("rst2_idle", 32'(idle), 1);
    check("rst2_error", 32'(protocol_error), 0);
    check("rst2_retired", 32'(retired_count), 0);
    rst_n     = 1'b1;
    mark_auto = 1'b1;
    tick();

    // marked low during marked_valid
    mark_ok = 1'b0;
    push_entry(16'h0055);
    enable_pulse();
    wait_op(1, 30);
    pulse_op_done(1);
    wait_marks(1'b1, 40);
    repeat (2) tick();
    mark_ok = 1'b1;
    check("nomatch_retired", 32'(retired_count), 1);
    check("nomatch_error", 32'(protocol_error), 1);

    check("left_ops", 32'(exp_op_q.size()), 0);
    check("left_marks", 32'(exp_mark_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
